// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: sizing helper, predictor counter encodings
// and BTB training actions.
package cpu_pkg;

    localparam int unsigned PC_INC = 4;

    typedef enum logic [1:0] {
        TRAIN_NONE,
        TRAIN_INC,
        TRAIN_DEC,
        TRAIN_ALLOC
    } train_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(value)) w = w + 1;
        return w;
    endfunction

    function automatic int unsigned ctr_weak_taken(input int unsigned ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

    function automatic int unsigned ctr_weak_not_taken(input int unsigned ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Saturating up/down counter next-state logic (combinational only).
module bp_sat_ctr #(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             inc,
    input  logic             dec,
    input  logic             en,
    output logic [CTR_W-1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (en) begin
            if (inc && !dec && (ctr != '1))
                ctr_next = ctr + CTR_W'(1);
            else if (dec && !inc && (ctr != '0))
                ctr_next = ctr - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters: combinational IF prediction,
// EX-stage mispredict/redirect resolution, training and saturating statistics.
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned STAT_W  = 16
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              En,
    input  logic [ADDR_W-1:0] IF_Addr,
    output logic              Pred_Taken,
    output logic [ADDR_W-1:0] Pred_Target,
    input  logic              Upd_Valid,
    input  logic [ADDR_W-1:0] Upd_PC,
    input  logic              Upd_Taken,
    input  logic [ADDR_W-1:0] Upd_Target,
    input  logic              Upd_PredTaken,
    input  logic [ADDR_W-1:0] Upd_PredTarget,
    output logic              Mispredict,
    output logic [ADDR_W-1:0] Redirect_PC,
    output logic [STAT_W-1:0] Br_Count,
    output logic [STAT_W-1:0] Miss_Count
);

    localparam int unsigned       IDX_W  = clog2(ENTRIES);
    localparam int unsigned       TAG_W  = ADDR_W - 2 - IDX_W;
    localparam logic [CTR_W-1:0]  CTR_WT = CTR_W'(ctr_weak_taken(CTR_W));
    localparam logic [CTR_W-1:0]  CTR_WN = CTR_W'(ctr_weak_not_taken(CTR_W));
    localparam logic [ADDR_W-1:0] INC    = ADDR_W'(PC_INC);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } btb_entry_t;

    btb_entry_t btb [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    btb_entry_t       if_entry;
    logic             if_hit;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    btb_entry_t       upd_entry;
    logic             upd_hit;
    logic             update;
    train_e           train;
    logic [CTR_W-1:0] ctr_next;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{IF_Addr[1:0], Upd_PC[1:0]};

    // Prediction reads the stored state, so a same-cycle update to the
    // same index is only seen by IF from the following cycle.
    assign if_idx      = IF_Addr[IDX_W+1:2];
    assign if_tag      = IF_Addr[ADDR_W-1:IDX_W+2];
    assign if_entry    = btb[if_idx];
    assign if_hit      = if_entry.valid && (if_entry.tag == if_tag);
    assign Pred_Taken  = if_hit && if_entry.ctr[CTR_W-1];
    assign Pred_Target = Pred_Taken ? if_entry.target : IF_Addr + INC;

    assign upd_idx     = Upd_PC[IDX_W+1:2];
    assign upd_tag     = Upd_PC[ADDR_W-1:IDX_W+2];
    assign upd_entry   = btb[upd_idx];
    assign upd_hit     = upd_entry.valid && (upd_entry.tag == upd_tag);
    assign update      = En && Upd_Valid;

    assign Mispredict  = update && ((Upd_Taken != Upd_PredTaken) ||
                                    (Upd_Taken && (Upd_Target != Upd_PredTarget)));
    assign Redirect_PC = Upd_Taken ? Upd_Target : Upd_PC + INC;

    always_comb begin
        train = TRAIN_NONE;
        if (update) begin
            if (upd_hit)
                train = Upd_Taken ? TRAIN_INC : TRAIN_DEC;
            else if (Upd_Taken)
                train = TRAIN_ALLOC;
        end
    end

    bp_sat_ctr #(
        .CTR_W(CTR_W)
    ) u_sat_ctr (
        .ctr     (upd_entry.ctr),
        .inc     (train == TRAIN_INC),
        .dec     (train == TRAIN_DEC),
        .en      (update && upd_hit),
        .ctr_next(ctr_next)
    );

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WN};
            end
        end else begin
            case (train)
                TRAIN_INC: begin
                    btb[upd_idx].ctr    <= ctr_next;
                    btb[upd_idx].target <= Upd_Target;
                end
                TRAIN_DEC: begin
                    btb[upd_idx].ctr <= ctr_next;
                end
                TRAIN_ALLOC: begin
                    btb[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: Upd_Target, ctr: CTR_WT};
                end
                default: ;
            endcase
        end
    end

    // Statistics stick at all-ones rather than wrapping.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            Br_Count   <= '0;
            Miss_Count <= '0;
        end else if (update) begin
            if (Br_Count != '1)
                Br_Count <= Br_Count + STAT_W'(1);
            if (Mispredict && (Miss_Count != '1))
                Miss_Count <= Miss_Count + STAT_W'(1);
        end
    end

endmodule
